// File: rtl/nios2_sysid_checker_pkg.sv
// Shared definitions for the system-ID checker: FSM encoding, sysid slave
// word addresses and the default expected ID/timestamp words.
package nios2_sysid_checker_pkg;

   // FSM encoding, fixed so status/debug consumers can decode state_dbg.
   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_RD_ID_REQ  = 3'd1;
   localparam logic [2:0] ST_RD_ID_WAIT = 3'd2;
   localparam logic [2:0] ST_RD_TS_REQ  = 3'd3;
   localparam logic [2:0] ST_RD_TS_WAIT = 3'd4;
   localparam logic [2:0] ST_DONE       = 3'd5;

   typedef enum logic [2:0] {
      IDLE       = ST_IDLE,
      RD_ID_REQ  = ST_RD_ID_REQ,
      RD_ID_WAIT = ST_RD_ID_WAIT,
      RD_TS_REQ  = ST_RD_TS_REQ,
      RD_TS_WAIT = ST_RD_TS_WAIT,
      DONE       = ST_DONE
   } sysid_state_e;

   // Word addresses inside the sysid slave.
   localparam logic ADDR_ID = 1'b0;
   localparam logic ADDR_TS = 1'b1;

   // Values a correctly built system reports.
   localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd7;
   localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1385656859;

   // True in the states that own the bus (a read is requested or outstanding).
   function automatic logic is_active(input sysid_state_e s);
      return (s == RD_ID_REQ) || (s == RD_ID_WAIT) ||
             (s == RD_TS_REQ) || (s == RD_TS_WAIT);
   endfunction

endpackage

// File: rtl/nios2_sysid_read_timer.sv
// Per-read watchdog: cleared when a read request starts, counts every cycle
// the read is in flight, and flags the cycle in which the budget runs out.
module nios2_sysid_read_timer #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clock,
   input  logic reset_n,
   input  logic load,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   // expired fires in the TIMEOUT_CYCLES-th counted cycle, i.e. while the
   // count still holds TIMEOUT_CYCLES-1; the edge closing it is the limit.
   localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count_q;

   assign expired = enable && (count_q == LAST_COUNT);

   // Clear on reset or on a new request; count while a read is in flight.
   always_ff @(posedge clock) begin
      if (!reset_n || load) begin
         count_q <= '0;
      end else if (enable && !expired) begin
         count_q <= count_q + CW'(1);
      end
   end

endmodule

// File: rtl/nios2_sysid_checker.sv
// Avalon-MM read master that reads the sysid slave (ID word, then timestamp
// word), compares both against expected values and reports the verdict.
//
// Bus handshake: a read is offered by holding avm_read=1 with a stable
// avm_address; it is accepted on the first edge where avm_read=1 and
// avm_waitrequest=0, after which avm_read drops. Data is taken on the edge
// where avm_readdatavalid=1, which may coincide with the accept edge. Only
// one read is ever outstanding, and readdatavalid outside a read is ignored.
module nios2_sysid_checker
   import nios2_sysid_checker_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
   parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter bit          AUTO_START     = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid,
   output logic [2:0]  state_dbg
);

   sysid_state_e state_q, state_d;

   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic        id_ok_q, id_ok_d;
   logic        ts_ok_q, ts_ok_d;
   logic        timeout_q, timeout_d;
   logic [31:0] id_value_q, id_value_d;
   logic [31:0] ts_value_q, ts_value_d;
   logic        addr_q, addr_d;
   logic        read_q, read_d;
   logic        auto_q, auto_d;

   logic        accept;
   logic        timer_load;
   logic        timer_enable;
   logic        timer_expired;

   assign accept       = read_q && !avm_waitrequest;
   assign timer_enable = is_active(state_q);

   nios2_sysid_read_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_read_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .load    (timer_load),
      .enable  (timer_enable),
      .expired (timer_expired)
   );

   // Next-state and next-output logic; every output is the registered copy.
   always_comb begin
      state_d    = state_q;
      id_ok_d    = id_ok_q;
      ts_ok_d    = ts_ok_q;
      timeout_d  = timeout_q;
      id_value_d = id_value_q;
      ts_value_d = ts_value_q;
      addr_d     = addr_q;
      read_d     = read_q;
      auto_d     = auto_q;
      timer_load = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      pass_d     = 1'b0;

      unique case (state_q)
         IDLE, DONE: begin
            // A new check wipes the previous verdict and captured words.
            if (start || auto_q) begin
               state_d    = RD_ID_REQ;
               read_d     = 1'b1;
               addr_d     = ADDR_ID;
               id_ok_d    = 1'b0;
               ts_ok_d    = 1'b0;
               timeout_d  = 1'b0;
               id_value_d = '0;
               ts_value_d = '0;
               auto_d     = 1'b0;
            end
         end

         RD_ID_REQ: begin
            if (accept && avm_readdatavalid) begin
               id_value_d = avm_readdata;
               id_ok_d    = (avm_readdata == EXPECTED_ID);
               state_d    = RD_TS_REQ;
               read_d     = 1'b1;
               addr_d     = ADDR_TS;
            end else if (timer_expired) begin
               timeout_d = 1'b1;
               read_d    = 1'b0;
               state_d   = DONE;
            end else if (accept) begin
               read_d  = 1'b0;
               state_d = RD_ID_WAIT;
            end
         end

         RD_ID_WAIT: begin
            if (avm_readdatavalid) begin
               id_value_d = avm_readdata;
               id_ok_d    = (avm_readdata == EXPECTED_ID);
               state_d    = RD_TS_REQ;
               read_d     = 1'b1;
               addr_d     = ADDR_TS;
            end else if (timer_expired) begin
               timeout_d = 1'b1;
               state_d   = DONE;
            end
         end

         RD_TS_REQ: begin
            if (accept && avm_readdatavalid) begin
               ts_value_d = avm_readdata;
               ts_ok_d    = (avm_readdata == EXPECTED_TS);
               read_d     = 1'b0;
               state_d    = DONE;
            end else if (timer_expired) begin
               timeout_d = 1'b1;
               read_d    = 1'b0;
               state_d   = DONE;
            end else if (accept) begin
               read_d  = 1'b0;
               state_d = RD_TS_WAIT;
            end
         end

         RD_TS_WAIT: begin
            if (avm_readdatavalid) begin
               ts_value_d = avm_readdata;
               ts_ok_d    = (avm_readdata == EXPECTED_TS);
               state_d    = DONE;
            end else if (timer_expired) begin
               timeout_d = 1'b1;
               state_d   = DONE;
            end
         end

         default: begin
            state_d = IDLE;
            read_d  = 1'b0;
         end
      endcase

      // Each new request gets a fresh timeout budget.
      timer_load = (state_d != state_q) &&
                   ((state_d == RD_ID_REQ) || (state_d == RD_TS_REQ));

      busy_d = is_active(state_d);
      done_d = (state_d == DONE);
      pass_d = done_d && id_ok_d && ts_ok_d && !timeout_d;
   end

   // State and output registers; reset drops the bus request immediately.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         id_ok_q    <= 1'b0;
         ts_ok_q    <= 1'b0;
         timeout_q  <= 1'b0;
         id_value_q <= '0;
         ts_value_q <= '0;
         addr_q     <= 1'b0;
         read_q     <= 1'b0;
         auto_q     <= AUTO_START;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         id_ok_q    <= id_ok_d;
         ts_ok_q    <= ts_ok_d;
         timeout_q  <= timeout_d;
         id_value_q <= id_value_d;
         ts_value_q <= ts_value_d;
         addr_q     <= addr_d;
         read_q     <= read_d;
         auto_q     <= auto_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign id_ok       = id_ok_q;
   assign ts_ok       = ts_ok_q;
   assign timeout     = timeout_q;
   assign id_value    = id_value_q;
   assign ts_value    = ts_value_q;
   assign avm_address = addr_q;
   assign avm_read    = read_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_nios2_sysid_checker.sv
// Bench for nios2_sysid_checker: a manually started instance with a short
// timeout and a configurable sysid slave, plus an auto-start instance.
module tb_nios2_sysid_checker;
   import nios2_sysid_checker_pkg::*;

   localparam logic [31:0] EXP_ID = 32'd7;
   localparam logic [31:0] EXP_TS = 32'd1385656859;
   localparam logic [31:0] BAD_TS = 32'h52A0_0000;
   localparam int          EXP_W  = 76;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, pass, id_ok, ts_ok, timeout;
   logic [31:0] id_value, ts_value;
   logic        avm_address, avm_read;
   logic        avm_waitrequest = 1'b0;
   logic [31:0] avm_readdata = 32'h0;
   logic        avm_readdatavalid = 1'b0;
   logic [2:0]  state_dbg;

   logic        reset_auto_n = 1'b0;
   logic        a_busy, a_done, a_pass, a_id_ok, a_ts_ok, a_timeout;
   logic [31:0] a_id_value, a_ts_value;
   logic        a_address, a_read;
   logic        a_wr = 1'b0;
   logic [31:0] a_data = 32'h0;
   logic        a_rdv = 1'b0;
   logic [2:0]  a_state;

   nios2_sysid_checker #(
      .TIMEOUT_CYCLES (8),
      .AUTO_START     (1'b0)
   ) dut (
      .clock (clock), .reset_n (reset_n), .start (start),
      .busy (busy), .done (done), .pass (pass),
      .id_ok (id_ok), .ts_ok (ts_ok), .timeout (timeout),
      .id_value (id_value), .ts_value (ts_value),
      .avm_address (avm_address), .avm_read (avm_read),
      .avm_waitrequest (avm_waitrequest), .avm_readdata (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid), .state_dbg (state_dbg)
   );

   nios2_sysid_checker #(
      .AUTO_START (1'b1)
   ) dut_auto (
      .clock (clock), .reset_n (reset_auto_n), .start (1'b0),
      .busy (a_busy), .done (a_done), .pass (a_pass),
      .id_ok (a_id_ok), .ts_ok (a_ts_ok), .timeout (a_timeout),
      .id_value (a_id_value), .ts_value (a_ts_value),
      .avm_address (a_address), .avm_read (a_read),
      .avm_waitrequest (a_wr), .avm_readdata (a_data),
      .avm_readdatavalid (a_rdv), .state_dbg (a_state)
   );

   // ---------------- sysid slave models ----------------
   int          id_wait_left = 0;
   bit          drop_ts = 1'b0;
   logic [31:0] id_data = EXP_ID;
   logic [31:0] ts_data = EXP_TS;
   bit          inject_rdv = 1'b0;
   logic [31:0] inject_data = 32'h0;
   bit          pend = 1'b0;
   logic        pend_addr = 1'b0;
   logic        acc_q[$];

   // Slave for dut: optional ID stalls, one-cycle read latency, optional
   // dropped TS response, and injected stray readdatavalid pulses.
   always @(negedge clock) begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = 32'h0;
      avm_waitrequest   = 1'b0;
      if (!reset_n) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = pend_addr ? ts_data : id_data;
            pend              = 1'b0;
         end
         if (inject_rdv) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = inject_data;
            inject_rdv        = 1'b0;
         end
         if (avm_read) begin
            if (avm_address == 1'b0 && id_wait_left > 0) begin
               avm_waitrequest = 1'b1;
               id_wait_left--;
            end else begin
               acc_q.push_back(avm_address);
               if (!(avm_address && drop_ts)) begin
                  pend      = 1'b1;
                  pend_addr = avm_address;
               end
            end
         end
      end
   end

   bit   a_pend = 1'b0;
   logic a_pend_addr = 1'b0;

   // Zero-wait, one-cycle-latency slave for the auto-start instance.
   always @(negedge clock) begin
      a_wr   = 1'b0;
      a_rdv  = a_pend;
      a_data = a_pend_addr ? EXP_TS : EXP_ID;
      a_pend = 1'b0;
      if (reset_auto_n && a_read) begin
         a_pend      = 1'b1;
         a_pend_addr = a_address;
      end
   end

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   int start_cyc = 0;
   logic [EXP_W-1:0] exp_q[$];

   task automatic do_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] lat, input logic p, input logic iok,
                           input logic tok, input logic to,
                           input logic [31:0] idv, input logic [31:0] tsv);
      exp_q.push_back({lat, p, iok, tok, to, idv, tsv});
   endtask

   // Pulse start so it is sampled at edge E0; returns just after E0.
   task automatic launch();
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1;
      start_cyc = cyc;
      start = 1'b0;
   endtask

   // Wait (bounded) for done, then compare against the oldest expectation.
   task automatic finish_run(input string tag);
      logic [EXP_W-1:0] e;
      for (int i = 0; i < 64 && done !== 1'b1; i++) begin
         @(posedge clock);
         #1;
      end
      e = exp_q.pop_front();
      do_check({tag, "_done"},     done, 32'd1);
      do_check({tag, "_latency"},  32'(cyc - start_cyc), 32'(e[75:68]));
      do_check({tag, "_pass"},     pass, 32'(e[67]));
      do_check({tag, "_id_ok"},    id_ok, 32'(e[66]));
      do_check({tag, "_ts_ok"},    ts_ok, 32'(e[65]));
      do_check({tag, "_timeout"},  timeout, 32'(e[64]));
      do_check({tag, "_id_value"}, id_value, e[63:32]);
      do_check({tag, "_ts_value"}, ts_value, e[31:0]);
      do_check({tag, "_busy"},     busy, 32'd0);
      do_check({tag, "_avm_read"}, avm_read, 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      do_check({tag, "_flags"},
               32'({busy, done, pass, id_ok, ts_ok, timeout, avm_read, avm_address}), 32'd0);
      do_check({tag, "_id_value"}, id_value, 32'd0);
      do_check({tag, "_ts_value"}, ts_value, 32'd0);
      do_check({tag, "_state"},    state_dbg, 32'(ST_IDLE));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      repeat (3) @(posedge clock);
      #1;
      check_all_zero("reset");
      do_check("auto_reset_flags",
               32'({a_busy, a_done, a_pass, a_id_ok, a_ts_ok, a_timeout, a_read, a_address}), 32'd0);
      reset_n = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check_all_zero("idle_no_autostart");

      // Nominal check: ID then TS, one read each.
      acc_q.delete();
      push_exp(8'd4, 1'b1, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS);
      launch();
      do_check("t1_e0_read", avm_read, 32'd1);
      do_check("t1_e0_addr", avm_address, 32'd0);
      do_check("t1_e0_busy", busy, 32'd1);
      finish_run("t1");
      do_check("t1_nreads", acc_q.size(), 32'd2);
      do_check("t1_addr0", 32'(acc_q[0]), 32'd0);
      do_check("t1_addr1", 32'(acc_q[1]), 32'd1);

      // Wrong timestamp.
      ts_data = BAD_TS;
      push_exp(8'd4, 1'b0, 1'b1, 1'b0, 1'b0, EXP_ID, BAD_TS);
      launch();
      finish_run("t2");
      ts_data = EXP_TS;

      // Three stall cycles on the ID read.
      id_wait_left = 3;
      acc_q.delete();
      push_exp(8'd7, 1'b1, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS);
      launch();
      for (int i = 0; i < 4; i++) begin
         do_check($sformatf("t3_stall%0d_read", i), avm_read, 32'd1);
         do_check($sformatf("t3_stall%0d_addr", i), avm_address, 32'd0);
         @(posedge clock);
         #1;
      end
      finish_run("t3");
      do_check("t3_nreads", acc_q.size(), 32'd2);

      // TS read never answers: timeout after 8 TS cycles.
      drop_ts = 1'b1;
      push_exp(8'd10, 1'b0, 1'b1, 1'b0, 1'b1, EXP_ID, 32'd0);
      launch();
      finish_run("t4");
      inject_data = EXP_TS;
      inject_rdv  = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      do_check("t4_late_ts_value", ts_value, 32'd0);
      do_check("t4_late_ts_ok", ts_ok, 32'd0);
      do_check("t4_late_done", done, 32'd1);

      // Reset while the TS read is outstanding, then a late readdatavalid.
      launch();
      repeat (3) @(posedge clock);
      #1;
      do_check("t5_pre_reset_state", state_dbg, 32'(ST_RD_TS_WAIT));
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      check_all_zero("t5_in_reset");
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      inject_data = EXP_TS;
      inject_rdv  = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check_all_zero("t5_late_data");
      drop_ts = 1'b0;

      // Start pulsed while busy is ignored.
      acc_q.delete();
      push_exp(8'd4, 1'b1, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS);
      launch();
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      finish_run("t5b");
      do_check("t5b_nreads", acc_q.size(), 32'd2);
      repeat (3) @(posedge clock);
      #1;
      do_check("t5b_still_done", done, 32'd1);
      do_check("t5b_not_busy", busy, 32'd0);

      // Auto-start instance: runs on its own after reset release.
      reset_auto_n = 1'b1;
      @(posedge clock);
      #1;
      do_check("t6_e0_state", a_state, 32'(ST_RD_ID_REQ));
      do_check("t6_e0_busy", a_busy, 32'd1);
      do_check("t6_e0_read", a_read, 32'd1);
      repeat (3) @(posedge clock);
      #1;
      do_check("t6_e3_done", a_done, 32'd0);
      @(posedge clock);
      #1;
      do_check("t6_e4_done", a_done, 32'd1);
      do_check("t6_e4_pass", a_pass, 32'd1);
      do_check("t6_id_value", a_id_value, EXP_ID);
      do_check("t6_ts_value", a_ts_value, EXP_TS);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
